uart_tx_mmio: RTL and testbench



---
 rtl/uart_mmio_pkg.sv | 21 ++
 rtl/sync_fifo.sv | 63 ++++++
 rtl/uart_tx_mmio.sv | 162 ++++++++++++++++
 tb/tb_uart_tx_mmio.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_mmio_pkg.sv
// Shared constants and types for the memory-mapped UART transmitter.
// Register offsets are word indices taken from A[3:2].
package uart_mmio_pkg;

  localparam logic [1:0] OFF_TXDATA = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_BAUD   = 2'd2;

  localparam int unsigned ST_FULL    = 0;
  localparam int unsigned ST_EMPTY   = 1;
  localparam int unsigned ST_BUSY    = 2;
  localparam int unsigned ST_OVF     = 3;
  localparam int unsigned ST_CNT_LSB = 4;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  function automatic logic [3:0] sat_count4(input logic [31:0] c);
    return (c > 32'd15) ? 4'hf : c[3:0];
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with combinational head output and occupancy count.
// A push while full is accepted only if a pop frees a slot on the same edge.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop) begin
      count_d = count_q + CW'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter on the core's data-memory bus.
// Register decode, baud counter and frame FSM; bytes are queued in sync_fifo.
module uart_tx_mmio
  import uart_mmio_pkg::*;
#(
  parameter logic [31:0]      BASE_ADDR   = 32'h0000_1000,
  parameter int unsigned      FIFO_DEPTH  = 8,
  parameter int unsigned      DIV_W       = 16,
  parameter logic [DIV_W-1:0] DEFAULT_DIV = 16'd868
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        WE,
  input  logic [31:0] A,
  input  logic [31:0] WD,
  output logic [31:0] RD,
  output logic        hit,
  output logic        tx,
  output logic        busy
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  tx_state_t        state_q, state_d;
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [DIV_W-1:0] baud_cnt_q, baud_cnt_d;
  logic [DIV_W-1:0] div_active_q, div_active_d;
  logic [DIV_W-1:0] baud_q, baud_d;
  logic             ovf_q, ovf_d;

  logic [1:0]    off;
  logic          wr;
  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]    fifo_dout;
  logic [CW-1:0] fifo_count;
  logic          bit_done;
  logic          unused_bits;

  assign hit         = (A[31:4] == BASE_ADDR[31:4]);
  assign off         = A[3:2];
  assign wr          = WE && hit;
  assign fifo_push   = wr && (off == OFF_TXDATA);
  assign busy        = (state_q != IDLE) || !fifo_empty;
  assign bit_done    = (baud_cnt_q == div_active_q - DIV_W'(1));
  assign unused_bits = ^{WD, A[1:0]};

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (WD[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Register writes; clearing overflow takes priority over a new overflow.
  always_comb begin
    baud_d = baud_q;
    ovf_d  = ovf_q;
    if (wr && (off == OFF_BAUD)) baud_d = WD[DIV_W-1:0];
    if (wr && (off == OFF_STATUS) && WD[ST_OVF]) begin
      ovf_d = 1'b0;
    end else if (fifo_push && fifo_full && !fifo_pop) begin
      ovf_d = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_idx_d    = bit_idx_q;
    baud_cnt_d   = baud_cnt_q;
    div_active_d = div_active_q;
    fifo_pop     = 1'b0;
    tx           = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop     = 1'b1;
          shift_d      = fifo_dout;
          div_active_d = (baud_q == '0) ? DIV_W'(1) : baud_q;
          baud_cnt_d   = '0;
          state_d      = START;
        end
      end
      START: begin
        tx = 1'b0;
        if (bit_done) begin
          baud_cnt_d = '0;
          bit_idx_d  = 3'd0;
          state_d    = DATA;
        end else begin
          baud_cnt_d = baud_cnt_q + DIV_W'(1);
        end
      end
      DATA: begin
        tx = shift_q[bit_idx_q];
        if (bit_done) begin
          baud_cnt_d = '0;
          if (bit_idx_q == 3'd7) state_d = STOP;
          else bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          baud_cnt_d = baud_cnt_q + DIV_W'(1);
        end
      end
      STOP: begin
        if (bit_done) begin
          baud_cnt_d = '0;
          state_d    = IDLE;
        end else begin
          baud_cnt_d = baud_cnt_q + DIV_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      bit_idx_q    <= '0;
      baud_cnt_q   <= '0;
      div_active_q <= DIV_W'(1);
      baud_q       <= DEFAULT_DIV;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_idx_q    <= bit_idx_d;
      baud_cnt_q   <= baud_cnt_d;
      div_active_q <= div_active_d;
      baud_q       <= baud_d;
      ovf_q        <= ovf_d;
    end
  end

  always_comb begin
    RD = '0;
    if (hit) begin
      case (off)
        OFF_STATUS: begin
          RD[ST_FULL]                 = fifo_full;
          RD[ST_EMPTY]                = fifo_empty;
          RD[ST_BUSY]                 = busy;
          RD[ST_OVF]                  = ovf_q;
          RD[ST_CNT_LSB+3:ST_CNT_LSB] = sat_count4(32'(fifo_count));
        end
        OFF_BAUD: RD[DIV_W-1:0] = baud_q;
        default:  RD = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Bench for uart_tx_mmio: directed bus stimulus plus a serial-line monitor
// that decodes 8N1 frames and checks them against a queue of expected bytes.
module tb_uart_tx_mmio;

  localparam logic [31:0] ADDR_TX     = 32'h0000_1000;
  localparam logic [31:0] ADDR_STATUS = 32'h0000_1004;
  localparam logic [31:0] ADDR_BAUD   = 32'h0000_1008;

  typedef struct {
    logic [7:0] data;
    int         div;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        WE = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] WD = '0;
  logic [31:0] RD;
  logic        hit, tx, busy;

  int   total = 0;
  int   bad = 0;
  exp_t exp_q[$];

  bit         mon_active = 1'b0;
  bit         mon_abort = 1'b0;
  int         mon_k = 0;
  exp_t       mon_e;
  logic [7:0] mon_data;

  always #5 clk = ~clk;

  uart_tx_mmio dut (
    .clk   (clk),
    .reset (reset),
    .WE    (WE),
    .A     (A),
    .WD    (WD),
    .RD    (RD),
    .hit   (hit),
    .tx    (tx),
    .busy  (busy)
  );

  // Serial monitor: frame start is the first low cycle; bits sampled mid-cell.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_abort) begin
        mon_active = 1'b0;
        mon_abort  = 1'b0;
      end else if (!mon_active) begin
        if (tx === 1'b0) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL spurious_frame: tx start bit observed, required idle line");
            mon_e.data = 8'h00;
            mon_e.div  = 1;
          end else begin
            mon_e = exp_q.pop_front();
          end
          mon_active = 1'b1;
          mon_k      = 0;
          mon_data   = 'x;
        end
      end else begin
        mon_k++;
        for (int i = 0; i < 8; i++) begin
          if (mon_k == mon_e.div * (1 + i) + mon_e.div / 2) mon_data[i] = tx;
        end
        if (mon_k == 9 * mon_e.div + mon_e.div / 2) begin
          total += 2;
          if (mon_data !== mon_e.data) begin
            bad++;
            $display("FAIL frame_data: got 0x%02h required 0x%02h (div %0d)",
                     mon_data, mon_e.data, mon_e.div);
          end
          if (tx !== 1'b1) begin
            bad++;
            $display("FAIL frame_stop: got %b required 1", tx);
          end
          mon_active = 1'b0;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  task automatic bus_wr(input logic [31:0] addr, input logic [31:0] data);
    A  = addr;
    WD = data;
    WE = 1'b1;
    @(posedge clk);
    @(negedge clk);
    WE = 1'b0;
  endtask

  task automatic store(input logic [7:0] b, input int div);
    exp_t e;
    e.data = b;
    e.div  = div;
    exp_q.push_back(e);
    bus_wr(ADDR_TX, {24'h0, b});
  endtask

  task automatic bus_rd(input logic [31:0] addr, output logic [31:0] v);
    WE = 1'b0;
    A  = addr;
    #1;
    v = RD;
  endtask

  task automatic drain(input int limit, output bit ok);
    int n = 0;
    while ((busy !== 1'b0 || mon_active) && n < limit) begin
      @(negedge clk);
      n++;
    end
    ok = (n < limit) && (exp_q.size() == 0);
  endtask

  task automatic test_reset;
    logic [31:0] v;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    bus_rd(ADDR_STATUS, v);
    total++;
    if (v !== 32'h0000_0002) begin
      bad++; $display("FAIL reset_status: got 0x%08h required 0x00000002", v);
    end
    bus_rd(ADDR_BAUD, v);
    total++;
    if (v !== 32'd868) begin
      bad++; $display("FAIL reset_baud: got %0d required 868", v);
    end
    total++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL reset_line: got tx=%b busy=%b required tx=1 busy=0", tx, busy);
    end
    bus_rd(32'h0000_0FFC, v);
    total++;
    if (hit !== 1'b0 || v !== 32'h0) begin
      bad++; $display("FAIL reset_miss: got hit=%b RD=0x%08h required hit=0 RD=0", hit, v);
    end
  endtask

  task automatic test_basic_frame;
    logic [31:0] v;
    logic [7:0]  b = 8'h55;
    logic        want;
    bus_wr(ADDR_BAUD, 32'd4);
    bus_rd(ADDR_BAUD, v);
    total++;
    if (v !== 32'd4) begin
      bad++; $display("FAIL baud_rw: got %0d required 4", v);
    end
    store(b, 4);
    bus_rd(ADDR_STATUS, v);
    total++;
    if (v !== 32'h0000_0014 || tx !== 1'b1) begin
      bad++; $display("FAIL after_store: got status 0x%08h tx=%b required 0x00000014 tx=1", v, tx);
    end
    @(posedge clk);
    @(negedge clk);
    for (int c = 0; c < 40; c++) begin
      if (c < 4) want = 1'b0;
      else if (c < 36) want = b[(c - 4) / 4];
      else want = 1'b1;
      total++;
      if (tx !== want) begin
        bad++; $display("FAIL wave_0x55 cycle %0d: got tx=%b required %b", c, tx, want);
      end
      @(posedge clk);
      @(negedge clk);
    end
    total++;
    if (busy !== 1'b0 || tx !== 1'b1 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL frame_end: got busy=%b tx=%b pending=%0d required busy=0 tx=1 pending=0",
               busy, tx, exp_q.size());
    end
  endtask

  task automatic test_overflow;
    logic [31:0] v;
    bit          ok;
    // The first byte leaves the FIFO one edge after its store, so the
    // tenth consecutive store is the one that finds the FIFO full.
    for (int i = 1; i <= 9; i++) store(8'(i), 4);
    bus_wr(ADDR_TX, 32'h0000_000A);
    bus_rd(ADDR_STATUS, v);
    total++;
    if (v !== 32'h0000_008D) begin
      bad++; $display("FAIL overflow_status: got 0x%08h required 0x0000008d", v);
    end
    bus_wr(ADDR_STATUS, 32'h0000_0008);
    bus_rd(ADDR_STATUS, v);
    total++;
    if (v !== 32'h0000_0085) begin
      bad++; $display("FAIL overflow_clear: got 0x%08h required 0x00000085", v);
    end
    drain(1500, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL overflow_drain: got busy=%b pending=%0d required idle and 0 pending",
                      busy, exp_q.size());
    end
  endtask

  task automatic test_baud_change;
    logic [31:0] v;
    bit          ok;
    store(8'hA5, 4);
    store(8'h3C, 2);
    repeat (14) @(negedge clk);
    bus_wr(ADDR_BAUD, 32'd2);
    bus_rd(ADDR_BAUD, v);
    total++;
    if (v !== 32'd2) begin
      bad++; $display("FAIL baud_midframe_rd: got %0d required 2", v);
    end
    drain(500, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL baud_change_drain: got busy=%b pending=%0d required idle and 0 pending",
                      busy, exp_q.size());
    end
  endtask

  task automatic test_div_zero;
    bit ok;
    bus_wr(ADDR_BAUD, 32'd0);
    store(8'h5A, 1);
    drain(200, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL div_zero_drain: got busy=%b pending=%0d required idle and 0 pending",
                      busy, exp_q.size());
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [31:0] v;
    int          lows = 0;
    bus_wr(ADDR_BAUD, 32'd4);
    store(8'h00, 4);
    store(8'h81, 4);
    // Frame began at the previous edge; land inside data bit 3.
    repeat (17) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset     = 1'b0;
    mon_abort = 1'b1;
    exp_q.delete();
    @(negedge clk);
    total++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL reset_mid_line: got tx=%b busy=%b required tx=1 busy=0", tx, busy);
    end
    bus_rd(ADDR_STATUS, v);
    total++;
    if (v !== 32'h0000_0002) begin
      bad++; $display("FAIL reset_mid_status: got 0x%08h required 0x00000002", v);
    end
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    total++;
    if (lows != 0) begin
      bad++; $display("FAIL reset_mid_quiet: got %0d non-idle cycles required 0", lows);
    end
  endtask

  task automatic test_unmapped;
    logic [31:0] v;
    bus_wr(32'h0000_100C, 32'h0000_00FF);
    bus_wr(32'h0000_2000, 32'h0000_0041);
    bus_rd(ADDR_STATUS, v);
    total++;
    if (v !== 32'h0000_0002) begin
      bad++; $display("FAIL unmapped_status: got 0x%08h required 0x00000002", v);
    end
    bus_rd(ADDR_BAUD, v);
    total++;
    if (v !== 32'd868) begin
      bad++; $display("FAIL unmapped_baud: got %0d required 868", v);
    end
    bus_rd(32'h0000_100C, v);
    total++;
    if (hit !== 1'b1 || v !== 32'h0) begin
      bad++; $display("FAIL reserved_rd: got hit=%b RD=0x%08h required hit=1 RD=0", hit, v);
    end
    bus_rd(32'h0000_2000, v);
    total++;
    if (hit !== 1'b0 || v !== 32'h0) begin
      bad++; $display("FAIL outside_rd: got hit=%b RD=0x%08h required hit=0 RD=0", hit, v);
    end
    bus_rd(ADDR_TX, v);
    total++;
    if (hit !== 1'b1 || v !== 32'h0) begin
      bad++; $display("FAIL txdata_rd: got hit=%b RD=0x%08h required hit=1 RD=0", hit, v);
    end
    repeat (5) @(negedge clk);
    total++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL unmapped_line: got tx=%b busy=%b required tx=1 busy=0", tx, busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_overflow();
    test_baud_change();
    test_div_zero();
    test_reset_mid_frame();
    test_unmapped();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
